ox_round_judge: RTL and testbench



---
 rtl/color_game_pkg.sv | 19 +
 rtl/key_sync_edge.sv | 22 ++
 rtl/ox_round_judge.sv | 117 +++++++++++
 tb/tb_ox_round_judge.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/color_game_pkg.sv
// Shared types and timing defaults for the Color Game round controller.
package color_game_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_GO,
        S_RESULT
    } state_t;

    localparam int CLK_HZ    = 50_000_000;
    localparam int CYCLES_1S = CLK_HZ;
    localparam int CYCLES_2S = 2 * CLK_HZ;

    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchroniser for an active-low key, plus a one-cycle press pulse on its falling edge.
module key_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '1;
        end else begin
            sh <= {sh[1:0], key_n};
        end
    end

    // sh[1] is the synchronised level, sh[2] its previous value
    assign press = sh[2] & ~sh[1];

endmodule

// File: rtl/ox_round_judge.sv
// Two-player reaction round: start, fixed delay, GO, then judge the first hit or foul.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for a start press
// S_WAIT   | counting the delay; any player press is a foul
// S_GO     | go lamp on, waiting for the first hit
// S_RESULT | winner flags held for HOLD_CYCLES
module ox_round_judge
    import color_game_pkg::*;
#(
    parameter int DELAY_CYCLES = CYCLES_1S,
    parameter int HOLD_CYCLES  = CYCLES_2S,
    parameter int SCORE_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_start_n,
    input  logic               key_p1_n,
    input  logic               key_p2_n,
    output logic               o,
    output logic               x,
    output logic               go,
    output logic               busy,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2
);

    localparam int                 CNT_W      = cnt_width(DELAY_CYCLES, HOLD_CYCLES);
    localparam logic [CNT_W-1:0]   DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    logic start_p, p1_p, p2_p;
    state_t state;
    logic [CNT_W-1:0] cnt;

    key_sync_edge u_sync_start (.clk(clk), .rst_n(rst_n), .key_n(key_start_n), .press(start_p));
    key_sync_edge u_sync_p1    (.clk(clk), .rst_n(rst_n), .key_n(key_p1_n),    .press(p1_p));
    key_sync_edge u_sync_p2    (.clk(clk), .rst_n(rst_n), .key_n(key_p2_n),    .press(p2_p));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            o        <= 1'b0;
            x        <= 1'b0;
            go       <= 1'b0;
            busy     <= 1'b0;
            score_p1 <= '0;
            score_p2 <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_p) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CNT_ONE;
                    if (p1_p && p2_p) begin
                        state <= S_RESULT;
                        cnt   <= '0;
                    end else if (p1_p) begin
                        // early press hands the round to the opponent
                        state <= S_RESULT;
                        cnt   <= '0;
                        x     <= 1'b1;
                        if (score_p2 != SCORE_MAX) score_p2 <= score_p2 + SCORE_ONE;
                    end else if (p2_p) begin
                        state <= S_RESULT;
                        cnt   <= '0;
                        o     <= 1'b1;
                        if (score_p1 != SCORE_MAX) score_p1 <= score_p1 + SCORE_ONE;
                    end else if (cnt == DELAY_LAST) begin
                        state <= S_GO;
                        cnt   <= '0;
                        go    <= 1'b1;
                    end
                end
                S_GO: begin
                    if (p1_p || p2_p) begin
                        state <= S_RESULT;
                        cnt   <= '0;
                        go    <= 1'b0;
                        if (p1_p && !p2_p) begin
                            o <= 1'b1;
                            if (score_p1 != SCORE_MAX) score_p1 <= score_p1 + SCORE_ONE;
                        end else if (p2_p && !p1_p) begin
                            x <= 1'b1;
                            if (score_p2 != SCORE_MAX) score_p2 <= score_p2 + SCORE_ONE;
                        end
                    end
                end
                S_RESULT: begin
                    cnt <= cnt + CNT_ONE;
                    if (cnt == HOLD_LAST) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        o     <= 1'b0;
                        x     <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ox_round_judge.sv
// Bench for ox_round_judge: round table, randomized rounds against an outcome model, and timing corners.
module tb_ox_round_judge;

    localparam int DELAY = 8;
    localparam int HOLD  = 4;
    localparam int SW    = 2;
    localparam int SMAX  = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic key_start_n, key_p1_n, key_p2_n;
    logic o, x, go, busy;
    logic [SW-1:0] score_p1, score_p2;

    int n_vec = 0;
    int n_err = 0;
    int m_s1  = 0;
    int m_s2  = 0;

    typedef struct {
        bit pre;   // press counted from WAIT entry instead of from GO
        int d;
        bit p1;
        bit p2;
        bit eo;
        bit ex;
        bit ego;
    } vec_t;

    vec_t tbl[9];

    ox_round_judge #(.DELAY_CYCLES(DELAY), .HOLD_CYCLES(HOLD), .SCORE_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .key_start_n(key_start_n), .key_p1_n(key_p1_n),
        .key_p2_n(key_p2_n), .o(o), .x(x), .go(go), .busy(busy),
        .score_p1(score_p1), .score_p2(score_p2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SMAX) ? SMAX : v;
    endfunction

    // Reference judging rules: simultaneous presses void the round, an early press loses it.
    function automatic void judge(input bit pre, input bit p1, input bit p2,
                                  output bit eo, output bit ex);
        if (p1 && p2) begin
            eo = 1'b0; ex = 1'b0;
        end else if (pre) begin
            eo = p2;   ex = p1;
        end else begin
            eo = p1;   ex = p2;
        end
    endfunction

    task automatic watch(input string tag, input bit eo, input bit ex, input bit ego,
                         input bit go_before, input bit keep);
        int oc, xc, rc;
        bit sg, both, done;
        oc = 0; xc = 0; rc = 0; sg = go_before; both = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (i == 0) begin
                key_start_n = 1'b1;
                if (!keep) begin
                    key_p1_n = 1'b1;
                    key_p2_n = 1'b1;
                end
            end
            if (!busy) begin
                done = 1'b1;
            end else begin
                if (go) sg = 1'b1;
                if (o) oc++;
                if (x) xc++;
                if (o && x) both = 1'b1;
                if (sg && !go) rc++;
            end
        end
        if (eo) m_s1 = sat(m_s1 + 1);
        if (ex) m_s2 = sat(m_s2 + 1);
        chk({tag, "_idle"}, int'(busy), 0);
        chk({tag, "_ocyc"}, oc, eo ? HOLD : 0);
        chk({tag, "_xcyc"}, xc, ex ? HOLD : 0);
        chk({tag, "_goseen"}, int'(sg), int'(ego));
        if (ego) chk({tag, "_rescyc"}, rc, HOLD);
        chk({tag, "_ox_excl"}, int'(both), 0);
        chk({tag, "_s1"}, int'(score_p1), m_s1);
        chk({tag, "_s2"}, int'(score_p2), m_s2);
    endtask

    task automatic play(input string tag, input vec_t v, input bit keep);
        int n;
        bit sg;
        sg = 1'b0;
        key_start_n = 1'b0;
        tick();
        key_start_n = 1'b1;
        n = 0;
        while (!busy && n < 10) begin tick(); n++; end
        if (!v.pre) begin
            n = 0;
            while (!go && n < 20) begin tick(); n++; end
            chk({tag, "_go"}, int'(go), 1);
            sg = go;
        end
        for (int i = 0; i < v.d; i++) begin
            tick();
            if (go) sg = 1'b1;
        end
        if (v.p1) key_p1_n = 1'b0;
        if (v.p2) key_p2_n = 1'b0;
        watch(tag, v.eo, v.ex, v.ego, sg, keep);
    endtask

    initial begin
        vec_t v;
        int n;
        bit eo, ex;

        tbl[0] = '{1'b0, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}; // P1 hit
        tbl[1] = '{1'b1, 3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // P2 foul
        tbl[2] = '{1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // P1 foul, first WAIT cycle
        tbl[3] = '{1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // double foul
        tbl[4] = '{1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}; // tie in GO
        tbl[5] = '{1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}; // P2 hit
        tbl[6] = '{1'b1, 5, 1'b1, 0, 1'b0, 1'b1, 1'b0};    // foul on last WAIT cycle
        tbl[7] = '{1'b1, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}; // lands on first GO cycle
        tbl[8] = '{1'b0, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}; // P1 hit, saturates

        rst_n = 1'b0;
        key_start_n = 1'b1; key_p1_n = 1'b1; key_p2_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o", int'(o), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_go", int'(go), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_s1", int'(score_p1), 0);
        chk("rst_s2", int'(score_p2), 0);
        rst_n = 1'b1;
        tick();

        // ignored inputs and go latency
        key_p1_n = 1'b0;
        tick();
        key_p1_n = 1'b1;
        repeat (5) tick();
        chk("ign_p1_idle_busy", int'(busy), 0);
        chk("ign_p1_idle_s1", int'(score_p1), 0);
        key_start_n = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) key_start_n = 1'b1;
            if (n == 4) key_start_n = 1'b0;
            if (n == 5) key_start_n = 1'b1;
        end while (!go && n < 30);
        chk("go_latency", n, 3 + DELAY);
        key_start_n = 1'b0;
        tick();
        key_start_n = 1'b1;
        repeat (5) tick();
        chk("ign_start_go", int'(go), 1);
        key_p1_n = 1'b0;
        tick();
        key_p1_n = 1'b0;
        key_start_n = 1'b0;
        watch("ign_start_result", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (6) tick();
        chk("ign_start_after", int'(busy), 0);

        for (int i = 0; i < 9; i++) begin
            play($sformatf("tbl%0d", i), tbl[i], 1'b0);
            tick();
        end

        // async reset mid-GO
        key_start_n = 1'b0;
        tick();
        key_start_n = 1'b1;
        n = 0;
        while (!go && n < 20) begin tick(); n++; end
        chk("arst_pre_go", int'(go), 1);
        #2;
        rst_n = 1'b0;
        #1;
        m_s1 = 0; m_s2 = 0;
        chk("arst_go", int'(go), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_o", int'(o), 0);
        chk("arst_x", int'(x), 0);
        chk("arst_s1", int'(score_p1), 0);
        chk("arst_s2", int'(score_p2), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        play("arst_round", tbl[0], 1'b0);

        // held P2 key across rounds, then saturation
        v = tbl[5];
        play("held1", v, 1'b1);
        key_start_n = 1'b0;
        tick();
        key_start_n = 1'b1;
        n = 0;
        while (!go && n < 20) begin tick(); n++; end
        repeat (6) tick();
        chk("held_no_win_go", int'(go), 1);
        chk("held_no_win_s2", int'(score_p2), m_s2);
        key_p2_n = 1'b1;
        tick();
        key_p2_n = 1'b0;
        watch("held2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        play("sat3", tbl[5], 1'b0);
        play("sat4", tbl[5], 1'b0);
        chk("sat_s2", int'(score_p2), SMAX);

        // randomized rounds against the judging model
        for (int r = 0; r < 30; r++) begin
            int mode;
            mode  = int'($urandom_range(0, 5));
            v.pre = (mode < 3);
            v.d   = v.pre ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 6));
            v.p1  = (mode == 0 || mode == 2 || mode == 3 || mode == 5);
            v.p2  = (mode == 1 || mode == 2 || mode == 4 || mode == 5);
            judge(v.pre, v.p1, v.p2, eo, ex);
            v.eo  = eo;
            v.ex  = ex;
            v.ego = !v.pre;
            play($sformatf("rnd%0d", r), v, 1'b0);
            repeat (int'($urandom_range(0, 3))) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
